lut_layer_sequencer: RTL and testbench

- Time-multiplexed evaluator for one quantised sparse layer. A single synchronous LUT RAM holds every neuron's truth table; the block evaluates one neuron per cycle.
- Each neuron's 8-bit address is gathered from a latched input activation vector through a per-neuron fan-in index table. Results are assembled into an output vector.
- Sits between layer stages in the pipecleaner flow. It replaces N_OUT distributed-ROM neurons when area matters more than throughput.
- LUT contents and index table are loaded at run time through a config port.

---
 rtl/lut_layer_pkg.sv | 48 ++++
 rtl/lut_layer_sequencer_if.sv | 22 ++
 rtl/lut_layer_ram.sv | 42 ++++
 rtl/lut_layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_lut_layer_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_layer_pkg.sv
// Shared constants, types and the fan-in gather helper for the LUT layer sequencer.
// Index-table config addresses are {neuron, slot} with a slot field one bit wider than needed.
package lut_layer_pkg;

   localparam int N_IN      = 16;
   localparam int IN_BW     = 2;
   localparam int FANIN     = 4;
   localparam int N_OUT     = 8;
   localparam int OUT_BW    = 2;
   localparam int IDX_W     = $clog2(N_IN);
   localparam int AW        = FANIN * IN_BW;
   localparam int NW        = $clog2(N_OUT);
   localparam int CNT_W     = $clog2(N_OUT + 1);
   localparam int SLOT_W    = $clog2(FANIN) + 1;
   localparam int CFG_AW    = NW + AW;
   localparam int CFG_DW    = (OUT_BW > IDX_W) ? OUT_BW : IDX_W;
   localparam int LUT_DEPTH = N_OUT << AW;
   localparam int IN_W      = N_IN * IN_BW;
   localparam int OUT_W     = N_OUT * OUT_BW;
   localparam int ROW_W     = FANIN * IDX_W;

   localparam logic CFG_SEL_LUT = 1'b0;
   localparam logic CFG_SEL_IDX = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [AW-1:0] gather_addr(input logic [IN_W-1:0]  in_vec,
                                                 input logic [ROW_W-1:0] idx_row);
      logic [AW-1:0]    addr;
      logic [IDX_W-1:0] idx;
      addr = '0;
      for (int j = 0; j < FANIN; j++) begin
         idx = idx_row[j*IDX_W +: IDX_W];
         // Indices past the last feature read as a zero-valued feature.
         if (int'(idx) < N_IN) begin
            addr[j*IN_BW +: IN_BW] = in_vec[idx*IN_BW +: IN_BW];
         end else begin
            addr[j*IN_BW +: IN_BW] = '0;
         end
      end
      return addr;
   endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Input-vector and output-vector stream handshakes of the LUT layer sequencer.
interface lut_layer_sequencer_if;
   import lut_layer_pkg::*;

   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_data;
   logic             m_valid;
   logic             m_ready;
   logic [OUT_W-1:0] m_data;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );

endinterface

// File: rtl/lut_layer_ram.sv
// Simple dual-port LUT RAM: one config write port, one read port with a registered output.
module lut_layer_ram #(
   parameter int DW       = 2,
   parameter int AW       = 11,
   parameter int DEPTH    = 2048,
   parameter bit USE_BRAM = 1'b0
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] rdata_q;

   generate
      if (USE_BRAM) begin : g_block
         (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (we_i) begin
               mem[waddr_i] <= wdata_i;
            end
            rdata_q <= mem[raddr_i];
         end
      end else begin : g_dist
         (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (we_i) begin
               mem[waddr_i] <= wdata_i;
            end
            rdata_q <= mem[raddr_i];
         end
      end
   endgenerate

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one sparse LUT layer: one neuron per cycle from a shared LUT RAM,
// each neuron's address gathered from the latched input vector through a fan-in index table.
module lut_layer_sequencer
   import lut_layer_pkg::*;
#(
   parameter bit USE_BRAM = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   lut_layer_sequencer_if.slave  stream,
   input  logic                  cfg_we,
   input  logic                  cfg_sel,
   input  logic [CFG_AW-1:0]     cfg_addr,
   input  logic [CFG_DW-1:0]     cfg_wdata,
   output logic                  cfg_err,
   output logic                  busy
);

   state_e            state_q;
   logic [CNT_W-1:0]  n_q;
   logic [IN_W-1:0]   in_q;
   logic [ROW_W-1:0]  idx_q [N_OUT];
   logic [OUT_W-1:0]  res_q;
   logic [OUT_W-1:0]  res_d;
   logic [OUT_W-1:0]  m_data_q;
   logic              s_ready_q;
   logic              m_valid_q;
   logic              cfg_err_q;
   logic              busy_q;

   logic              accept_s;
   logic              cfg_ok_s;
   logic              lut_we_s;
   logic              idx_we_s;
   logic [SLOT_W-1:0] cfg_slot_s;
   logic [NW-1:0]     cfg_nrn_s;
   logic [NW-1:0]     rd_nrn_s;
   logic [NW-1:0]     wr_nrn_s;
   logic [CFG_AW-1:0] rd_addr_s;
   logic [OUT_BW-1:0] rd_data_s;

   // Config acceptance, read-address gather and result-slot update.
   always_comb begin
      accept_s   = stream.s_valid && s_ready_q;
      cfg_slot_s = cfg_addr[SLOT_W-1:0];
      cfg_nrn_s  = cfg_addr[SLOT_W +: NW];
      cfg_ok_s   = 1'b0;
      if (cfg_we && (state_q == IDLE) && !accept_s) begin
         if (cfg_sel == CFG_SEL_LUT) begin
            cfg_ok_s = 1'b1;
         end else begin
            cfg_ok_s = (int'(cfg_slot_s) < FANIN);
         end
      end else begin
         cfg_ok_s = 1'b0;
      end
      lut_we_s  = cfg_ok_s && (cfg_sel == CFG_SEL_LUT);
      idx_we_s  = cfg_ok_s && (cfg_sel == CFG_SEL_IDX);

      rd_nrn_s  = n_q[NW-1:0];
      rd_addr_s = {rd_nrn_s, gather_addr(in_q, idx_q[rd_nrn_s])};
      // The RAM word arriving now belongs to the neuron issued one cycle earlier.
      wr_nrn_s  = rd_nrn_s - NW'(1);
      res_d     = res_q;
      if ((state_q == RUN) && (n_q != '0)) begin
         res_d[wr_nrn_s*OUT_BW +: OUT_BW] = rd_data_s;
      end else begin
         res_d = res_q;
      end
   end

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         n_q       <= '0;
         in_q      <= '0;
         res_q     <= '0;
         m_data_q  <= '0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         cfg_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         cfg_err_q <= cfg_we && !cfg_ok_s;
         res_q     <= res_d;
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  in_q      <= stream.s_data;
                  n_q       <= '0;
                  state_q   <= RUN;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            RUN: begin
               if (n_q == CNT_W'(N_OUT)) begin
                  state_q   <= DONE;
                  m_valid_q <= 1'b1;
                  m_data_q  <= res_d;
               end else begin
                  n_q <= n_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (stream.m_ready) begin
                  state_q   <= IDLE;
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               m_valid_q <= 1'b0;
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Fan-in index table; cleared by reset, written only from accepted config writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N_OUT; n++) begin
            idx_q[n] <= '0;
         end
      end else if (idx_we_s) begin
         idx_q[cfg_nrn_s][cfg_slot_s[SLOT_W-2:0]*IDX_W +: IDX_W] <= cfg_wdata[IDX_W-1:0];
      end
   end

   lut_layer_ram #(
      .DW       (OUT_BW),
      .AW       (CFG_AW),
      .DEPTH    (LUT_DEPTH),
      .USE_BRAM (USE_BRAM)
   ) u_ram (
      .clk     (clk),
      .we_i    (lut_we_s),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_wdata[OUT_BW-1:0]),
      .raddr_i (rd_addr_s),
      .rdata_o (rd_data_s)
   );

   assign stream.s_ready = s_ready_q;
   assign stream.m_valid = m_valid_q;
   assign stream.m_data  = m_data_q;
   assign cfg_err        = cfg_err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: directed scenarios plus random LUT/index/vector
// traffic checked against a behavioural layer model held in plain integer arrays.
module tb_lut_layer_sequencer;
   import lut_layer_pkg::*;

   localparam int LUT_SPAN = 1 << AW;
   localparam int LAT      = N_OUT + 2;
   localparam int PERIOD   = N_OUT + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic              cfg_sel;
   logic [CFG_AW-1:0] cfg_addr;
   logic [CFG_DW-1:0] cfg_wdata;
   logic              cfg_err;
   logic              busy;

   lut_layer_sequencer_if sif ();

   lut_layer_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .stream    (sif.slave),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_tests    = 0;
   int n_fail     = 0;
   int err_pulses = 0;
   int bulk_err   = 0;
   int lut_m [LUT_DEPTH];
   int idx_m [N_OUT][FANIN];

   always @(negedge clk) if (cfg_err === 1'b1) err_pulses++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference layer: per neuron, build the LUT address from the indexed features, then look up.
   function automatic logic [OUT_W-1:0] model_out(input logic [IN_W-1:0] vec);
      logic [OUT_W-1:0] r;
      int a, f, id;
      r = '0;
      for (int n = 0; n < N_OUT; n++) begin
         a = 0;
         for (int j = 0; j < FANIN; j++) begin
            id = idx_m[n][j];
            f  = (id < N_IN) ? (int'(vec >> (id * IN_BW)) & 3) : 0;
            a  = a + (f << (j * IN_BW));
         end
         r = r | (OUT_W'(lut_m[n * LUT_SPAN + a]) << (n * OUT_BW));
      end
      return r;
   endfunction

   function automatic logic [IN_W-1:0] set_feat(input logic [IN_W-1:0] vec, input int i, input int v);
      logic [IN_W-1:0] m;
      m = IN_W'(3) << (i * IN_BW);
      return (vec & ~m) | ((IN_W'(v) << (i * IN_BW)) & m);
   endfunction

   task automatic cfg_write(input bit sel, input int addr, input int data, output bit err);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_addr  = CFG_AW'(addr);
      cfg_wdata = CFG_DW'(data);
      step();
      cfg_we    = 1'b0;
      err       = cfg_err;
   endtask

   task automatic program_lut(input int n, input int mode);
      bit e;
      int v;
      for (int a = 0; a < LUT_SPAN; a++) begin
         case (mode)
            1:       v = a & 3;
            2:       v = (a >> 4) & 3;
            3:       v = int'($urandom_range(0, 3));
            4:       v = (a == 'hB4) ? 3 : 0;
            default: v = 0;
         endcase
         cfg_write(1'b0, n * LUT_SPAN + a, v, e);
         if (e) bulk_err++;
         lut_m[n * LUT_SPAN + a] = v;
      end
   endtask

   task automatic program_idx(input int n, input int slot, input int val);
      bit e;
      cfg_write(1'b1, (n << SLOT_W) + slot, val, e);
      if (e) bulk_err++;
      idx_m[n][slot] = val;
   endtask

   task automatic clear_idx_model();
      for (int n = 0; n < N_OUT; n++)
         for (int j = 0; j < FANIN; j++) idx_m[n][j] = 0;
   endtask

   task automatic wait_mvalid(output int lat, output bit to);
      lat = 1;
      while (!sif.m_valid && lat < 40) begin
         step();
         lat++;
      end
      to = !sif.m_valid;
   endtask

   task automatic send(input logic [IN_W-1:0] vec, output logic [OUT_W-1:0] data,
                       output int lat, output bit to);
      sif.s_valid = 1'b1;
      sif.s_data  = vec;
      step();
      sif.s_valid = 1'b0;
      wait_mvalid(lat, to);
      data        = sif.m_data;
      sif.m_ready = 1'b1;
      step();
      sif.m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_tests++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", sif.s_ready); end
      n_tests++; if (sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", sif.m_valid); end
      n_tests++; if (sif.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0000", sif.m_data); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
      rst = 1'b0;
      clear_idx_model();
      bulk_err = 0;
      for (int n = 0; n < N_OUT; n++) program_lut(n, 0);
      n_tests++; if (bulk_err !== 0) begin n_fail++; $display("FAIL lut_clear_writes: got %0d rejects expected 0", bulk_err); end
   endtask

   task automatic test_all_zero();
      logic [OUT_W-1:0] d;
      int lat, e0;
      bit to;
      e0 = err_pulses;
      send('0, d, lat, to);
      n_tests++; if (to || lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d (timeout %b) expected %0d", lat, to, LAT); end
      n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL zero_data: got %h expected 0000", d); end
      n_tests++; if (err_pulses !== e0) begin n_fail++; $display("FAIL zero_cfg_err: got %0d pulses expected 0", err_pulses - e0); end
   endtask

   task automatic test_identity();
      logic [OUT_W-1:0] d;
      logic [IN_W-1:0]  v;
      int lat;
      bit to;
      bulk_err = 0;
      for (int n = 0; n < N_OUT; n++) begin
         program_idx(n, 0, n);
         program_lut(n, 1);
      end
      v = '0;
      for (int i = 0; i < N_IN; i++) v = set_feat(v, i, i % 4);
      send(v, d, lat, to);
      n_tests++; if (d !== 16'hE4E4) begin n_fail++; $display("FAIL identity_const: got %h expected e4e4", d); end
      n_tests++; if (d !== model_out(v)) begin n_fail++; $display("FAIL identity_model: got %h expected %h", d, model_out(v)); end
      n_tests++; if (bulk_err !== 0) begin n_fail++; $display("FAIL identity_cfg: got %0d rejects expected 0", bulk_err); end
   endtask

   task automatic test_full_decode(output logic [IN_W-1:0] vec);
      logic [OUT_W-1:0] d;
      logic [IN_W-1:0]  v;
      int lat;
      bit to;
      program_lut(3, 4);
      program_idx(3, 0, 5);
      program_idx(3, 1, 1);
      program_idx(3, 2, 4);
      program_idx(3, 3, 2);
      v = IN_W'($urandom);
      v = set_feat(v, 5, 0);
      v = set_feat(v, 1, 1);
      v = set_feat(v, 4, 3);
      v = set_feat(v, 2, 2);
      vec = v;
      send(v, d, lat, to);
      n_tests++; if (d[7:6] !== 2'b11) begin n_fail++; $display("FAIL decode_hit: got %b expected 11", d[7:6]); end
      n_tests++; if (d !== model_out(v)) begin n_fail++; $display("FAIL decode_hit_model: got %h expected %h", d, model_out(v)); end
      v = set_feat(v, 4, 2);
      send(v, d, lat, to);
      n_tests++; if (d[7:6] !== 2'b00) begin n_fail++; $display("FAIL decode_miss: got %b expected 00", d[7:6]); end
      n_tests++; if (d !== model_out(v)) begin n_fail++; $display("FAIL decode_miss_model: got %h expected %h", d, model_out(v)); end
   endtask

   task automatic test_backpressure(input logic [IN_W-1:0] vec);
      logic [OUT_W-1:0] d, exp_d;
      int lat;
      bit to, e;
      exp_d = model_out(vec);
      sif.s_valid = 1'b1;
      sif.s_data  = vec;
      step();
      sif.s_valid = 1'b1;
      wait_mvalid(lat, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL bp_wait: got timeout expected m_valid"); end
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if (sif.m_valid !== 1'b1 || sif.s_ready !== 1'b0 || sif.m_data !== exp_d || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h busy=%b expected v=1 r=0 d=%h busy=1",
                     i, sif.m_valid, sif.s_ready, sif.m_data, busy, exp_d);
         end
         if (i == 5) begin
            cfg_write(1'b0, 3 * LUT_SPAN + 'hB4, 0, e);
            n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL bp_cfg_err: got %b expected 1", e); end
            step();
            n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL bp_cfg_err_width: got %b expected 0", cfg_err); end
         end else begin
            step();
         end
      end
      sif.s_valid = 1'b0;
      sif.m_ready = 1'b1;
      step();
      sif.m_ready = 1'b0;
      n_tests++; if (sif.m_valid !== 1'b0 || sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", sif.m_valid, sif.s_ready); end
      // Config write coincident with an input accept.
      sif.s_valid = 1'b1;
      sif.s_data  = vec;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = CFG_AW'(3 * LUT_SPAN + 'hB4); cfg_wdata = '0;
      step();
      cfg_we = 1'b0;
      sif.s_valid = 1'b0;
      n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL clash_cfg_err: got %b expected 1", cfg_err); end
      wait_mvalid(lat, to);
      d = sif.m_data;
      sif.m_ready = 1'b1;
      step();
      sif.m_ready = 1'b0;
      n_tests++; if (to || d !== exp_d) begin n_fail++; $display("FAIL clash_data: got %h (timeout %b) expected %h", d, to, exp_d); end
      send(vec, d, lat, to);
      n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL lut_unchanged: got %h expected %h", d, exp_d); end
   endtask

   task automatic test_reset_mid();
      logic [OUT_W-1:0] d;
      logic [IN_W-1:0]  v;
      int lat, seen;
      bit to;
      v = IN_W'($urandom);
      sif.s_valid = 1'b1;
      sif.s_data  = v;
      step();
      sif.s_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_idx_model();
      n_tests++; if (sif.m_valid !== 1'b0 || sif.s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL run_reset: got v=%b r=%b busy=%b expected v=0 r=1 busy=0", sif.m_valid, sif.s_ready, busy); end
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (sif.m_valid === 1'b1) seen++;
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL run_reset_no_output: got %0d valid cycles expected 0", seen); end
      sif.s_valid = 1'b1;
      sif.s_data  = v;
      step();
      sif.s_valid = 1'b0;
      wait_mvalid(lat, to);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if (to || sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL done_reset: got v=%b (timeout %b) expected v=0", sif.m_valid, to); end
      v = IN_W'($urandom);
      send(v, d, lat, to);
      n_tests++; if (d !== model_out(v)) begin n_fail++; $display("FAIL post_reset_data: got %h expected %h", d, model_out(v)); end
   endtask

   task automatic test_idx_range();
      logic [OUT_W-1:0] d;
      logic [IN_W-1:0]  v;
      int lat;
      bit to, e;
      program_lut(5, 2);
      cfg_write(1'b1, (5 << SLOT_W) + 2, 15, e);
      n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL idx_slot2_accept: got err %b expected 0", e); end
      idx_m[5][2] = 15;
      cfg_write(1'b1, (5 << SLOT_W) + 4, 9, e);
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL idx_slot4_reject: got err %b expected 1", e); end
      cfg_write(1'b1, (6 << SLOT_W) + 7, 3, e);
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL idx_slot7_reject: got err %b expected 1", e); end
      v = set_feat(IN_W'($urandom), 15, 2);
      send(v, d, lat, to);
      n_tests++; if (d[11:10] !== 2'b10) begin n_fail++; $display("FAIL idx15_feature: got %b expected 10", d[11:10]); end
      n_tests++; if (d !== model_out(v)) begin n_fail++; $display("FAIL idx15_model: got %h expected %h", d, model_out(v)); end
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] d;
      logic [IN_W-1:0]  v;
      int lat;
      bit to;
      bulk_err = 0;
      for (int n = 0; n < N_OUT; n++) begin
         program_lut(n, 3);
         for (int j = 0; j < FANIN; j++) program_idx(n, j, int'($urandom_range(0, N_IN - 1)));
      end
      n_tests++; if (bulk_err !== 0) begin n_fail++; $display("FAIL rand_cfg: got %0d rejects expected 0", bulk_err); end
      for (int t = 0; t < 8; t++) begin
         v = IN_W'($urandom);
         send(v, d, lat, to);
         n_tests++;
         if (to || lat !== LAT || d !== model_out(v)) begin
            n_fail++;
            $display("FAIL rand_vec[%0d]: got %h lat %0d expected %h lat %0d", t, d, lat, model_out(v), LAT);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0]  vecs [4];
      logic [OUT_W-1:0] exp_q [$];
      logic [OUT_W-1:0] e;
      int acc_cyc [4];
      int cyc, sent, got;
      for (int i = 0; i < 4; i++) vecs[i] = IN_W'($urandom);
      cyc = 0; sent = 0; got = 0;
      sif.s_valid = 1'b1;
      sif.s_data  = vecs[0];
      sif.m_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         if (sif.s_valid && sif.s_ready) begin
            acc_cyc[sent] = cyc;
            exp_q.push_back(model_out(vecs[sent]));
            sent++;
         end
         if (sif.m_valid && sif.m_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_tests++; if (sif.m_data !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, sif.m_data, e); end
            got++;
         end
         step();
         cyc++;
         if (sent < 4) sif.s_data = vecs[sent];
         else sif.s_valid = 1'b0;
      end
      sif.s_valid = 1'b0;
      sif.m_ready = 1'b0;
      n_tests++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", got); end
      for (int i = 1; i < 4; i++) begin
         n_tests++;
         if (i < sent && acc_cyc[i] - acc_cyc[i-1] !== PERIOD) begin
            n_fail++;
            $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], PERIOD);
         end
      end
   endtask

   initial begin
      logic [IN_W-1:0] dec_vec;
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_sel     = 1'b0;
      cfg_addr    = '0;
      cfg_wdata   = '0;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.m_ready = 1'b0;
      test_reset();
      test_all_zero();
      test_identity();
      test_full_decode(dec_vec);
      test_backpressure(dec_vec);
      test_reset_mid();
      test_idx_range();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
